// File: rtl/gpu_pkg.sv
// Shared types and constants for the wave dispatcher.
package gpu_pkg;

    localparam int DEF_WAVE_SIZE = 32;
    localparam int DEF_WID_W     = 8;

    localparam logic [DEF_WID_W-1:0] INVALID_WAVE_ID = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DISPATCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Wrapped half: requesters below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_i))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_dispatch_rr.sv
// Splits one thread block into waves and hands them round-robin to SIMD units
// with a per-SIMD limit on outstanding waves.
module wave_dispatch_rr
    import gpu_pkg::*;
#(
    parameter int NUM_SIMDS  = 4,
    parameter int WAVE_SIZE  = DEF_WAVE_SIZE,
    parameter int SIMD_DEPTH = 2,
    parameter int WID_W      = DEF_WID_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          num_threads,
    input  logic [31:0]          block_dim,
    input  logic                 blk_valid,
    input  logic [31:0]          blk_id,
    output logic                 blk_ready,
    output logic                 disp_valid,
    output logic [NUM_SIMDS-1:0] disp_sel,
    output logic [WID_W-1:0]     disp_wave_id,
    output logic [WAVE_SIZE-1:0] disp_lane_mask,
    input  logic [NUM_SIMDS-1:0] disp_ready,
    input  logic [NUM_SIMDS-1:0] wave_done,
    output logic                 busy,
    output logic                 block_done,
    output logic                 err_underflow
);

    localparam int PW = (NUM_SIMDS > 1) ? $clog2(NUM_SIMDS) : 1;
    localparam int LW = $clog2(WAVE_SIZE);

    state_e               state_q, state_d;
    logic [31:0]          blk_id_q;
    logic [31:0]          nwaves_q, nwaves_d;
    logic [LW-1:0]        rem_q, rem_d;
    logic [31:0]          disp_cnt_q, disp_cnt_d;
    logic [31:0]          done_cnt_q, done_cnt_d;
    logic [31:0]          outst_q [NUM_SIMDS];
    logic [31:0]          outst_d [NUM_SIMDS];
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 locked_q;
    logic [NUM_SIMDS-1:0] sel_q;
    logic                 err_q, err_d;

    logic [NUM_SIMDS-1:0] elig, grant;
    logic [PW-1:0]        sel_idx;
    logic                 xfer, last_wave, offer_pending;
    logic [31:0]          bd_safe, rem_thr, nblk, blk_thr, setup_waves;

    // Block geometry, evaluated while in SETUP with blk_id_q already latched.
    always_comb begin
        bd_safe     = (block_dim == 32'd0) ? 32'd1 : block_dim;
        rem_thr     = num_threads % bd_safe;
        nblk        = (num_threads / bd_safe) + ((rem_thr != 32'd0) ? 32'd1 : 32'd0);
        blk_thr     = ((blk_id_q == nblk - 32'd1) && (rem_thr != 32'd0)) ? rem_thr : block_dim;
        setup_waves = (blk_thr >> LW) + {31'd0, |blk_thr[LW-1:0]};
    end

    always_comb begin
        for (int i = 0; i < NUM_SIMDS; i++) begin
            elig[i] = outst_q[i] < 32'(SIMD_DEPTH);
        end
    end

    rr_arbiter #(
        .N  (NUM_SIMDS),
        .PW (PW)
    ) u_arb (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // A stalled offer is locked so the target never changes until accepted.
    always_comb begin
        offer_pending  = (state_q == ST_DISPATCH) && (disp_cnt_q < nwaves_q);
        disp_valid     = offer_pending && (locked_q || (|elig));
        disp_sel       = !disp_valid ? '0 : (locked_q ? sel_q : grant);
        xfer           = disp_valid && (|(disp_sel & disp_ready));
        last_wave      = (disp_cnt_q == nwaves_q - 32'd1);
        disp_wave_id   = disp_valid ? disp_cnt_q[WID_W-1:0] : '0;
        disp_lane_mask = '0;
        if (disp_valid) begin
            disp_lane_mask = (last_wave && (rem_q != '0)) ? ~({WAVE_SIZE{1'b1}} << rem_q) : '1;
        end
        sel_idx = '0;
        for (int i = 0; i < NUM_SIMDS; i++) begin
            if (disp_sel[i]) sel_idx = PW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        nwaves_d   = nwaves_q;
        rem_d      = rem_q;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        disp_cnt_d = disp_cnt_q + (xfer ? 32'd1 : 32'd0);
        ptr_d      = ptr_q;
        if (xfer) begin
            ptr_d = (sel_idx == PW'(NUM_SIMDS - 1)) ? '0 : sel_idx + 1'b1;
        end
        // Transfer and completion on one SIMD cancel; completions with nothing outstanding are flagged.
        for (int i = 0; i < NUM_SIMDS; i++) begin
            outst_d[i] = outst_q[i];
            if (wave_done[i] && (outst_q[i] == 32'd0)) begin
                err_d = 1'b1;
            end
            if (wave_done[i] && (outst_q[i] != 32'd0)) begin
                done_cnt_d = done_cnt_d + 32'd1;
                if (!(xfer && disp_sel[i])) outst_d[i] = outst_q[i] - 32'd1;
            end else if (xfer && disp_sel[i]) begin
                outst_d[i] = outst_q[i] + 32'd1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                nwaves_d = setup_waves;
                rem_d    = blk_thr[LW-1:0];
                state_d  = ((block_dim == 32'd0) || (blk_id_q >= nblk)) ? ST_DONE : ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (xfer && last_wave) begin
                    state_d = (done_cnt_d == nwaves_q) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done_cnt_d == nwaves_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                disp_cnt_d = '0;
                done_cnt_d = '0;
                for (int i = 0; i < NUM_SIMDS; i++) outst_d[i] = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            blk_id_q   <= '0;
            nwaves_q   <= '0;
            rem_q      <= '0;
            disp_cnt_q <= '0;
            done_cnt_q <= '0;
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            sel_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_SIMDS; i++) outst_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            if (blk_valid && blk_ready) blk_id_q <= blk_id;
            nwaves_q   <= nwaves_d;
            rem_q      <= rem_d;
            disp_cnt_q <= disp_cnt_d;
            done_cnt_q <= done_cnt_d;
            ptr_q      <= ptr_d;
            locked_q   <= disp_valid && !xfer;
            sel_q      <= disp_sel;
            err_q      <= err_d;
            for (int i = 0; i < NUM_SIMDS; i++) outst_q[i] <= outst_d[i];
        end
    end

    assign blk_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign block_done    = (state_q == ST_DONE);
    assign err_underflow = err_q;

endmodule

// File: doc/wave_dispatch_rr.md
WAVE_DISPATCH_RR -- requirements
Module: wave_dispatch_rr

Interface
REQ-001 SHALL have parameter NUM_SIMDS, default 4: number of SIMD units served.
REQ-002 SHALL have parameter WAVE_SIZE, default 32: threads per wave, power of two.
REQ-003 SHALL have parameter SIMD_DEPTH, default 2: maximum outstanding waves per SIMD.
REQ-004 SHALL have parameter WID_W, default 8: wave-id width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have ports num_threads and block_dim, input, 32 each: kernel totals, stable while busy=1.
REQ-008 SHALL have port blk_valid, input, 1, and port blk_id, input, 32: block offer.
REQ-009 SHALL have port blk_ready, output, 1: the block is accepted on blk_valid&&blk_ready.
REQ-010 SHALL have port disp_valid, output, 1, and port disp_sel, output, NUM_SIMDS: a one-hot target SIMD.
REQ-011 SHALL have port disp_wave_id, output, WID_W, and port disp_lane_mask, output, WAVE_SIZE: active lanes.
REQ-012 SHALL have port disp_ready, input, NUM_SIMDS: per-SIMD accept.
REQ-013 SHALL have port wave_done, input, NUM_SIMDS: a one-cycle pulse per completed wave.
REQ-014 SHALL have outputs busy, block_done (a one-cycle pulse) and err_underflow (sticky), 1 bit each.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, DISPATCH, DRAIN and DONE; blk_ready SHALL be 1 only in IDLE.
REQ-016 IDLE SHALL go to SETUP on accept, latching blk_id, and SETUP SHALL register the wave count.
- num_blocks = ceil(num_threads/block_dim).
- Block threads = block_dim, except the last block: remainder (num_threads mod block_dim), or block_dim if remainder = 0.
- num_waves = ceil(threads/WAVE_SIZE).
REQ-017 SETUP SHALL go straight to DONE if block_dim = 0 or blk_id >= num_blocks; otherwise it SHALL go to DISPATCH.
REQ-018 disp_valid SHALL rise no later than the second cycle after the accept edge and only in DISPATCH.
- A SIMD is eligible when its outstanding count < SIMD_DEPTH.
- Selection SHALL be round-robin starting after the last-granted SIMD; after reset the pointer starts at SIMD 0.
REQ-019 Once disp_valid=1, disp_sel, disp_wave_id and disp_lane_mask SHALL hold stable until disp_ready[sel]=1 (no retargeting).
REQ-020 A transfer SHALL increment that SIMD's outstanding count and the dispatched count.
- Wave ids SHALL be issued 0..num_waves-1 in order.
- The next offer SHALL follow in the next cycle if any SIMD is eligible.
REQ-021 disp_lane_mask SHALL be all ones, except on the last wave of a block with threads mod WAVE_SIZE = r != 0, where it SHALL have the low r bits set.
REQ-022 wave_done[i] SHALL decrement SIMD i's outstanding count and increment the done count.
- With outstanding = 0, the pulse SHALL be ignored and SHALL set err_underflow.
REQ-023 A transfer and a wave_done on the same SIMD in the same cycle SHALL leave its count unchanged.
- Multiple wave_done bits in one cycle SHALL all be counted.
REQ-024 DISPATCH SHALL go to DRAIN after the last transfer, and DRAIN SHALL go to DONE when the done count = num_waves.
- If the last done coincides with the last transfer, DISPATCH SHALL go directly to DONE.
REQ-025 DONE SHALL assert block_done for exactly one cycle, clear all counts, and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Counters SHALL be 32-bit with no wrap within a block; a wave id SHALL be the count truncated to WID_W.

Reset
REQ-028 rst_n=0 SHALL immediately force the following, including mid-block:
- state IDLE and round-robin pointer 0;
- blk_ready 1;
- disp_valid, disp_sel, disp_wave_id, disp_lane_mask, busy, block_done and err_underflow 0;
- all outstanding, dispatched and done counts 0.
- In-flight waves are abandoned.
REQ-029 Reset release SHALL take effect on the first rising edge of clk after rst_n returns to 1.

Structure
REQ-030 Package gpu_pkg SHALL hold the FSM state enum, the default WAVE_SIZE and WID_W, and the INVALID_WAVE_ID constant (all ones).
REQ-031 Round-robin selection SHALL be a separate sub-module rr_arbiter (request vector and pointer in, one-hot grant out).

Verification
REQ-032 Scenario: num_threads=256, block_dim=128, blk_id=0, all disp_ready=1.
- Required: 4 waves, ids 0-3, masks all ones, sel order SIMD0,1,2,3.
- Required: block_done one cycle after the 4th wave_done.
REQ-033 Scenario: num_threads=200, block_dim=128, blk_id=1.
- Required: 72 threads, 3 waves, the last mask 0x000000FF.
- Required: blk_id=2 gives an immediate block_done and no dispatch.
REQ-034 Scenario: NUM_SIMDS=2, SIMD_DEPTH=2, 6 waves, no wave_done.
- Required: 4 transfers, then disp_valid stays 0.
- Required: wave_done[1] resumes dispatch to SIMD1.
REQ-035 Scenario: disp_ready low for 5 cycles.
- Required: disp_valid, sel, id and mask stable for the whole stall; the transfer happens on the 6th cycle.
REQ-036 Scenario: a spurious wave_done[0] while idle.
- Required: err_underflow=1 and the counts unchanged.
- Then: a simultaneous transfer and wave_done on SIMD0 leave its count constant.
REQ-037 Scenario: rst_n pulsed low mid-DISPATCH.
- Required: outputs at their reset values asynchronously.
- Then: a new block is accepted normally.
